// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multiply/divide sequencer owning HI/LO with D-stage stall generation
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     one-cycle pulse: E-stage mult/multu/div/divu
//   md_op     00 mult, 01 multu, 10 div, 11 divu (sampled with start)
//   A, B      forwarded rs / rt operands
//   mthi/mtlo write A into HI/LO while idle
//   md_use_D  D-stage instruction depends on the HI/LO unit
//   busy      operation in flight
//   stall_md  freeze PC/IF-ID, bubble ID-EX
//   HI, LO    architectural HI/LO registers
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
    localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi_q, pend_lo_q;
    logic        pend_we_q;

    logic [63:0] prod_s, prod_u;
    logic        is_signed, a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;
    logic [31:0] pend_hi_d, pend_lo_d;
    logic        pend_we_d;

    // Result is computed from the operands present with start and parked in
    // pend_* until the counter expires, so HI/LO never show a partial value.
    always_comb begin
        prod_s    = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u    = {32'd0, A} * {32'd0, B};
        is_signed = ~md_op[0];
        a_neg     = is_signed & A[31];
        b_neg     = is_signed & B[31];
        a_mag     = a_neg ? (32'd0 - A) : A;
        b_mag     = b_neg ? (32'd0 - B) : B;
        div_zero  = (B == 32'd0);
        // Substitute a harmless divisor on /0; the result is discarded anyway.
        b_div     = div_zero ? 32'd1 : b_mag;
        // Magnitude division avoids signed-overflow on 0x80000000 / -1:
        // 0x80000000 / 1 negated twice stays 0x80000000 with remainder 0.
        q_mag     = a_mag / b_div;
        r_mag     = a_mag % b_div;
        quot      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem       = a_neg ? (32'd0 - r_mag) : r_mag;

        pend_hi_d = 32'd0;
        pend_lo_d = 32'd0;
        pend_we_d = 1'b1;
        case (md_op)
            2'b00:   {pend_hi_d, pend_lo_d} = prod_s;
            2'b01:   {pend_hi_d, pend_lo_d} = prod_u;
            default: begin
                pend_hi_d = rem;
                pend_lo_d = quot;
                pend_we_d = ~div_zero;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pend_hi_q <= pend_hi_d;
                        pend_lo_q <= pend_lo_d;
                        pend_we_q <= pend_we_d;
                        cnt_q     <= md_op[1] ? DIV_N : MULT_N;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                    end else begin
                        if (mthi) hi_q <= A;
                        if (mtlo) lo_q <= A;
                    end
                end
                S_RUN: begin
                    // start/mthi/mtlo are ignored here to protect HI/LO.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (pend_we_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign HI       = hi_q;
    assign LO       = lo_q;
    // Includes the start cycle itself and drops with busy so mfhi/mflo
    // enter E exactly when final HI/LO are visible.
    assign stall_md = md_use_D & (start | busy_q);

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - self-checking bench for md_ctrl
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        md_use_D = 1'b0;
    logic        busy, stall_md;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .mthi(mthi), .mtlo(mtlo), .md_use_D(md_use_D),
        .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, need finish)");
        $fatal(1, "watchdog");
    end

    // Drives one operation from a negedge and waits (bounded) for busy to fall.
    // Returns how many sampled cycles busy and stall_md were high.
    task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic use_d, output int busy_cnt, output int stall_cnt,
                            output bit timeout);
        busy_cnt  = 0;
        stall_cnt = 0;
        timeout   = 1'b0;
        start = 1'b1; md_op = op; A = a; B = b; md_use_D = use_d;
        #1;
        if (stall_md) stall_cnt++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            busy_cnt++;
            if (stall_md) stall_cnt++;
            @(negedge clk);
        end
        if (busy) timeout = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h need 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h need 0", LO); end
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b need 0", stall_md); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith(input string name, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                              input int n);
        int bc, sc; bit to; logic [63:0] e;
        exp_q.push_back({eh, el});
        issue_op(op, a, b, 1'b0, bc, sc, to);
        e = exp_q.pop_front();
        checks++; if (to || bc != n) begin errors++; $display("FAIL %s_busy_cycles: got %0d (timeout=%0d) need %0d", name, bc, to, n); end
        checks++; if (HI !== e[63:32]) begin errors++; $display("FAIL %s_hi: got %h need %h", name, HI, e[63:32]); end
        checks++; if (LO !== e[31:0]) begin errors++; $display("FAIL %s_lo: got %h need %h", name, LO, e[31:0]); end
        checks++; if (sc != 0) begin errors++; $display("FAIL %s_no_stall: got %0d stall cycles need 0", name, sc); end
    endtask

    task automatic test_mt();
        mthi = 1'b1; mtlo = 1'b1; A = 32'h1234;
        @(posedge clk); @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; A = 32'h5678;
        @(posedge clk); @(negedge clk);
        mtlo = 1'b0;
        checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mt_hi: got %h need 00001234", HI); end
        checks++; if (LO !== 32'h5678) begin errors++; $display("FAIL mt_lo: got %h need 00005678", LO); end
    endtask

    task automatic test_div_zero();
        int bc, sc; bit to;
        mthi = 1'b1; A = 32'h11;
        @(posedge clk); @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; A = 32'h22;
        @(posedge clk); @(negedge clk);
        mtlo = 1'b0;
        exp_q.push_back({32'h11, 32'h22});
        issue_op(2'b11, 32'd7, 32'd0, 1'b0, bc, sc, to);
        checks++; if (to || bc != 10) begin errors++; $display("FAIL divz_busy_cycles: got %0d need 10", bc); end
        checks++; if ({HI, LO} !== exp_q[0]) begin errors++; $display("FAIL divz_hilo: got %h need %h", {HI, LO}, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_stall();
        int bc, sc; bit to;
        issue_op(2'b00, 32'd3, 32'd4, 1'b1, bc, sc, to);
        checks++; if (sc != 6) begin errors++; $display("FAIL stall_cycles: got %0d need 6", sc); end
        #1;
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL stall_after: got %b need 0", stall_md); end
        checks++; if (LO !== 32'd12) begin errors++; $display("FAIL stall_lo: got %h need 0000000c", LO); end
        @(negedge clk);
        md_use_D = 1'b0;
        issue_op(2'b10, 32'd9, 32'd2, 1'b0, bc, sc, to);
        checks++; if (sc != 0) begin errors++; $display("FAIL stall_never: got %0d need 0", sc); end
    endtask

    task automatic test_start_mt_same();
        int bc, sc; bit to;
        mthi = 1'b1; mtlo = 1'b1;
        issue_op(2'b00, 32'd7, 32'd6, 1'b0, bc, sc, to);
        mthi = 1'b0; mtlo = 1'b0;
        checks++; if (HI !== 32'd0 || LO !== 32'd42) begin errors++; $display("FAIL start_wins: got %h_%h need 00000000_0000002a", HI, LO); end
    endtask

    task automatic test_busy_ignore();
        int bc;
        mthi = 1'b1; A = 32'hAAAA;
        @(posedge clk); @(negedge clk);
        mthi = 1'b0;
        exp_q.push_back({32'd0, 32'd42});
        start = 1'b1; md_op = 2'b00; A = 32'd7; B = 32'd6;
        @(posedge clk); @(negedge clk);
        bc = 1;
        start = 1'b1; md_op = 2'b11; mthi = 1'b1; mtlo = 1'b1; A = 32'hDEADBEEF; B = 32'd1;
        @(posedge clk); @(negedge clk);
        if (busy) bc++;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checks++; if (HI !== 32'hAAAA) begin errors++; $display("FAIL busy_mthi_ignored: got %h need 0000aaaa", HI); end
        for (int i = 0; i < 40 && busy; i++) begin
            @(negedge clk);
            if (busy) bc++;
        end
        checks++; if (bc != 5) begin errors++; $display("FAIL busy_start_ignored: got %0d busy cycles need 5", bc); end
        checks++; if ({HI, LO} !== exp_q[0]) begin errors++; $display("FAIL busy_result: got %h need %h", {HI, LO}, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid();
        mthi = 1'b1; mtlo = 1'b1; A = 32'h5555;
        @(posedge clk); @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        start = 1'b1; md_op = 2'b10; A = 32'd100; B = 32'd3;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b need 0", busy); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL rstmid_hilo: got %h_%h need 0_0", HI, LO); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_arith("post_rst_mult", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    endtask

    task automatic test_back_to_back();
        test_arith("b2b_div", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
        test_arith("b2b_divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        test_arith("b2b_mult", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 5);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_arith("mult", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        test_arith("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        test_arith("div", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        test_arith("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
        test_div_zero();
        test_mt();
        test_stall();
        test_start_mt_same();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
